// File: rtl/logic32_resp_checker_if.sv
// Bus between a stimulus/response source and the logic32 response checker.
// The master drives operands, results and CLR; the checker reports counters and status.
interface logic32_resp_checker_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
);
  logic             CLR;
  logic             IN_VALID;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [1:0]       OP;
  logic             Y_VALID;
  logic [WIDTH-1:0] Y;
  logic [CNT_W-1:0] PASS_CNT;
  logic [CNT_W-1:0] FAIL_CNT;
  logic [CNT_W-1:0] TXN_IDX;
  logic             ERR;
  logic [CNT_W-1:0] FIRST_IDX;
  logic [WIDTH-1:0] FIRST_EXP;
  logic [WIDTH-1:0] FIRST_GOT;
  logic             OVERFLOW;
  logic             UNDERFLOW;
  logic [1:0]       STATE;

  modport master (
    output CLR, IN_VALID, A, B, OP, Y_VALID, Y,
    input  PASS_CNT, FAIL_CNT, TXN_IDX, ERR, FIRST_IDX, FIRST_EXP, FIRST_GOT,
           OVERFLOW, UNDERFLOW, STATE
  );

  modport slave (
    input  CLR, IN_VALID, A, B, OP, Y_VALID, Y,
    output PASS_CNT, FAIL_CNT, TXN_IDX, ERR, FIRST_IDX, FIRST_EXP, FIRST_GOT,
           OVERFLOW, UNDERFLOW, STATE
  );
endinterface

// File: rtl/logic32_resp_checker.sv
// Response checker for AND/OR/NOR/XOR logic units: queues expected results on issue,
// compares them against returned results, and keeps pass/fail statistics.
module logic32_resp_checker #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  logic32_resp_checker_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_BUSY = 2'b01;
  localparam logic [1:0] ST_FAIL = 2'b10;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_count;
  logic [CNT_W-1:0] r_pass;
  logic [CNT_W-1:0] r_fail;
  logic [CNT_W-1:0] r_txn;
  logic             r_err;
  logic [CNT_W-1:0] r_first_idx;
  logic [WIDTH-1:0] r_first_exp;
  logic [WIDTH-1:0] r_first_got;
  logic             r_ovf;
  logic             r_udf;
  logic [1:0]       r_state;

  logic [WIDTH-1:0] w_exp;
  logic [WIDTH-1:0] w_head;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_mismatch;
  logic [AW:0]      w_count_nxt;
  logic [1:0]       w_state_nxt;

  always_comb begin
    w_exp = '0;
    case (bus.OP)
      2'b00:   w_exp = bus.A & bus.B;
      2'b01:   w_exp = bus.A | bus.B;
      2'b10:   w_exp = ~(bus.A | bus.B);
      default: w_exp = bus.A ^ bus.B;
    endcase
  end

  // A full queue still accepts a push when the head is popped in the same cycle.
  assign w_head      = r_mem[r_rd];
  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == FULL_CNT);
  assign w_pop       = bus.Y_VALID && !w_empty;
  assign w_push      = bus.IN_VALID && (!w_full || w_pop);
  assign w_mismatch  = w_pop && (bus.Y != w_head);
  assign w_count_nxt = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);

  // CLR releases FAIL and also masks a same-cycle mismatch.
  always_comb begin
    w_state_nxt = r_state;
    if (bus.CLR || (!w_mismatch && r_state != ST_FAIL))
      w_state_nxt = (w_count_nxt != '0) ? ST_BUSY : ST_IDLE;
    else if (w_mismatch)
      w_state_nxt = ST_FAIL;
  end

  always_ff @(posedge CLK) begin
    if (w_push)
      r_mem[r_wr] <= w_exp;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_wr        <= '0;
      r_rd        <= '0;
      r_count     <= '0;
      r_pass      <= '0;
      r_fail      <= '0;
      r_txn       <= '0;
      r_err       <= 1'b0;
      r_first_idx <= '0;
      r_first_exp <= '0;
      r_first_got <= '0;
      r_ovf       <= 1'b0;
      r_udf       <= 1'b0;
      r_state     <= ST_IDLE;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      r_count <= w_count_nxt;
      r_state <= w_state_nxt;
      if (bus.CLR) begin
        r_pass      <= '0;
        r_fail      <= '0;
        r_txn       <= '0;
        r_err       <= 1'b0;
        r_first_idx <= '0;
        r_first_exp <= '0;
        r_first_got <= '0;
        r_ovf       <= 1'b0;
        r_udf       <= 1'b0;
      end else begin
        if (w_pop) begin
          r_txn <= r_txn + CNT_W'(1);
          if (!w_mismatch && r_pass != '1) r_pass <= r_pass + CNT_W'(1);
          if (w_mismatch && r_fail != '1)  r_fail <= r_fail + CNT_W'(1);
          if (w_mismatch && !r_err) begin
            r_err       <= 1'b1;
            r_first_idx <= r_txn;
            r_first_exp <= w_head;
            r_first_got <= bus.Y;
          end
        end
        if (bus.IN_VALID && w_full && !w_pop) r_ovf <= 1'b1;
        if (bus.Y_VALID && w_empty)            r_udf <= 1'b1;
      end
    end
  end

  assign bus.PASS_CNT  = r_pass;
  assign bus.FAIL_CNT  = r_fail;
  assign bus.TXN_IDX   = r_txn;
  assign bus.ERR       = r_err;
  assign bus.FIRST_IDX = r_first_idx;
  assign bus.FIRST_EXP = r_first_exp;
  assign bus.FIRST_GOT = r_first_got;
  assign bus.OVERFLOW  = r_ovf;
  assign bus.UNDERFLOW = r_udf;
  assign bus.STATE     = r_state;
endmodule

// File: tb/tb_logic32_resp_checker.sv
// Directed bench for logic32_resp_checker: a per-cycle vector table plus
// hand-written sequences for queue full/overflow, saturation and reset.
module tb_logic32_resp_checker;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 CLK = ~CLK;

  logic32_resp_checker_if #(.WIDTH(32), .CNT_W(16)) bus ();
  logic32_resp_checker_if #(.WIDTH(32), .CNT_W(2))  sbus ();

  logic32_resp_checker #(.WIDTH(32), .DEPTH(4), .CNT_W(16)) u_dut (
    .CLK(CLK), .RST(RST), .bus(bus)
  );
  logic32_resp_checker #(.WIDTH(32), .DEPTH(4), .CNT_W(2)) u_small (
    .CLK(CLK), .RST(RST), .bus(sbus)
  );

  typedef struct {
    logic        iv;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic        yv;
    logic [31:0] y;
    logic        clr;
    logic [15:0] pass;
    logic [15:0] fail;
    logic [15:0] txn;
    logic        err;
    logic [15:0] fidx;
    logic [31:0] fexp;
    logic [31:0] fgot;
    logic        ovf;
    logic        udf;
    logic [1:0]  st;
  } vec_t;

  vec_t vt [18];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic check_all(input string t, input logic [15:0] pass, input logic [15:0] fail,
                           input logic [15:0] txn, input logic err, input logic [15:0] fidx,
                           input logic [31:0] fexp, input logic [31:0] fgot, input logic ovf,
                           input logic udf, input logic [1:0] st);
    chk({t, ".PASS_CNT"},  32'(bus.PASS_CNT),  32'(pass));
    chk({t, ".FAIL_CNT"},  32'(bus.FAIL_CNT),  32'(fail));
    chk({t, ".TXN_IDX"},   32'(bus.TXN_IDX),   32'(txn));
    chk({t, ".ERR"},       32'(bus.ERR),       32'(err));
    chk({t, ".FIRST_IDX"}, 32'(bus.FIRST_IDX), 32'(fidx));
    chk({t, ".FIRST_EXP"}, bus.FIRST_EXP,      fexp);
    chk({t, ".FIRST_GOT"}, bus.FIRST_GOT,      fgot);
    chk({t, ".OVERFLOW"},  32'(bus.OVERFLOW),  32'(ovf));
    chk({t, ".UNDERFLOW"}, 32'(bus.UNDERFLOW), 32'(udf));
    chk({t, ".STATE"},     32'(bus.STATE),     32'(st));
  endtask

  task automatic cyc(input logic iv, input logic [31:0] a, input logic [31:0] b,
                     input logic [1:0] op, input logic yv, input logic [31:0] y, input logic clr);
    bus.IN_VALID = iv; bus.A = a; bus.B = b; bus.OP = op;
    bus.Y_VALID = yv; bus.Y = y; bus.CLR = clr;
    @(posedge CLK); #1;
    bus.IN_VALID = 1'b0; bus.Y_VALID = 1'b0; bus.CLR = 1'b0;
  endtask

  task automatic scyc(input logic iv, input logic [31:0] a, input logic [31:0] b,
                      input logic [1:0] op, input logic yv, input logic [31:0] y);
    sbus.IN_VALID = iv; sbus.A = a; sbus.B = b; sbus.OP = op;
    sbus.Y_VALID = yv; sbus.Y = y; sbus.CLR = 1'b0;
    @(posedge CLK); #1;
    sbus.IN_VALID = 1'b0; sbus.Y_VALID = 1'b0;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    cyc(1'b1, a, b, op, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic ret(input logic [31:0] y);
    cyc(1'b0, 32'h0, 32'h0, 2'b00, 1'b1, y, 1'b0);
  endtask

  task automatic clr();
    cyc(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b1);
  endtask

  initial begin
    // iv a b op yv y clr | pass fail txn err fidx fexp fgot ovf udf st
    vt[0]  = '{1, 32'hFFFFFFFF, 32'h80000001, 2'b00, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01};
    vt[1]  = '{0, 32'h0, 32'h0, 2'b00, 1, 32'h80000001, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00};
    vt[2]  = '{0, 32'h0, 32'h0, 2'b00, 0, 32'h0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00};
    vt[3]  = '{1, 32'h1, 32'h5, 2'b00, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01};
    vt[4]  = '{0, 32'h0, 32'h0, 2'b00, 1, 32'h0, 0, 0, 1, 1, 1, 0, 1, 0, 0, 0, 2'b10};
    vt[5]  = '{1, 32'h3, 32'h0, 2'b01, 0, 32'h0, 0, 0, 1, 1, 1, 0, 1, 0, 0, 0, 2'b10};
    vt[6]  = '{0, 32'h0, 32'h0, 2'b00, 1, 32'h7, 0, 0, 2, 2, 1, 0, 1, 0, 0, 0, 2'b10};
    vt[7]  = '{0, 32'h0, 32'h0, 2'b00, 0, 32'h0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00};
    vt[8]  = '{1, 32'hF0, 32'h0F, 2'b11, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01};
    vt[9]  = '{0, 32'h0, 32'h0, 2'b00, 1, 32'hFF, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00};
    vt[10] = '{0, 32'h0, 32'h0, 2'b00, 1, 32'hFF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00};
    vt[11] = '{0, 32'h0, 32'h0, 2'b00, 0, 32'h0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00};
    vt[12] = '{1, 32'h2, 32'h6, 2'b00, 1, 32'h2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b01};
    vt[13] = '{0, 32'h0, 32'h0, 2'b00, 1, 32'h2, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 2'b00};
    vt[14] = '{0, 32'h0, 32'h0, 2'b00, 0, 32'h0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00};
    vt[15] = '{1, 32'h0, 32'h0, 2'b10, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01};
    vt[16] = '{0, 32'h0, 32'h0, 2'b00, 1, 32'h7FFFFFFF, 0, 0, 1, 1, 1, 0, 32'hFFFFFFFF, 32'h7FFFFFFF, 0, 0, 2'b10};
    vt[17] = '{0, 32'h0, 32'h0, 2'b00, 0, 32'h0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00};

    bus.IN_VALID = 1'b0; bus.A = '0; bus.B = '0; bus.OP = '0;
    bus.Y_VALID = 1'b0; bus.Y = '0; bus.CLR = 1'b0;
    sbus.IN_VALID = 1'b0; sbus.A = '0; sbus.B = '0; sbus.OP = '0;
    sbus.Y_VALID = 1'b0; sbus.Y = '0; sbus.CLR = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
    check_all("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);

    for (int i = 0; i < 18; i++) begin
      cyc(vt[i].iv, vt[i].a, vt[i].b, vt[i].op, vt[i].yv, vt[i].y, vt[i].clr);
      check_all($sformatf("vec%0d", i), vt[i].pass, vt[i].fail, vt[i].txn, vt[i].err,
                vt[i].fidx, vt[i].fexp, vt[i].fgot, vt[i].ovf, vt[i].udf, vt[i].st);
    end

    // Four mixed ops fill the queue, a fifth is dropped, results come back late.
    push(32'h2, 32'h6, 2'b00);
    push(32'h0, 32'h2, 2'b01);
    push(32'h6, 32'h2, 2'b10);
    push(32'h1, 32'h3, 2'b11);
    check_all("fill4", 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01);
    push(32'h0, 32'h0, 2'b01);
    check_all("ovf", 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b01);
    @(posedge CLK); #1;
    ret(32'h2);
    ret(32'h2);
    ret(32'hFFFFFFF9);
    check_all("late3", 3, 0, 3, 0, 0, 0, 0, 1, 0, 2'b01);
    ret(32'h2);
    check_all("late4", 4, 0, 4, 0, 0, 0, 0, 1, 0, 2'b00);
    ret(32'h0);
    check_all("dropped", 4, 0, 4, 0, 0, 0, 0, 1, 1, 2'b00);
    clr();

    // Simultaneous push and pop on a full queue.
    push(32'h1, 32'h1, 2'b00);
    push(32'h2, 32'h2, 2'b00);
    push(32'h4, 32'h4, 2'b00);
    push(32'h8, 32'h8, 2'b00);
    cyc(1'b1, 32'h10, 32'h10, 2'b00, 1'b1, 32'h1, 1'b0);
    check_all("fullpp", 1, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01);
    ret(32'h2);
    ret(32'h4);
    ret(32'h8);
    check_all("drain3", 4, 0, 4, 0, 0, 0, 0, 0, 0, 2'b01);
    ret(32'h10);
    check_all("drain4", 5, 0, 5, 0, 0, 0, 0, 0, 0, 2'b00);
    ret(32'h10);
    check_all("drain_udf", 5, 0, 5, 0, 0, 0, 0, 0, 1, 2'b00);
    clr();

    // Narrow counters: failures saturate, the transaction index wraps.
    for (int k = 0; k < 5; k++) begin
      scyc(1'b1, 32'h1, 32'h1, 2'b00, 1'b0, 32'h0);
      scyc(1'b0, 32'h0, 32'h0, 2'b00, 1'b1, 32'h0);
    end
    chk("small.FAIL_CNT",  32'(sbus.FAIL_CNT),  32'd3);
    chk("small.TXN_IDX",   32'(sbus.TXN_IDX),   32'd1);
    chk("small.PASS_CNT",  32'(sbus.PASS_CNT),  32'd0);
    chk("small.ERR",       32'(sbus.ERR),       32'd1);
    chk("small.FIRST_IDX", 32'(sbus.FIRST_IDX), 32'd0);
    chk("small.STATE",     32'(sbus.STATE),     32'd2);

    // Reset mid-traffic with entries outstanding and an error latched.
    push(32'h1, 32'h1, 2'b00);
    ret(32'h0);
    push(32'h1, 32'h2, 2'b01);
    push(32'h3, 32'h5, 2'b11);
    push(32'h7, 32'h1, 2'b00);
    check_all("pre_rst", 0, 1, 1, 1, 0, 32'h1, 32'h0, 0, 0, 2'b10);
    RST = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b1;
    check_all("mid_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
    ret(32'h3);
    check_all("post_rst", 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
